// File: rtl/spi_xfer_arbiter_pkg.sv
// spi_xfer_arbiter_pkg: shared state encoding, default timing and sizing helper
package spi_xfer_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, HOLD, GAP} spi_arb_state_e;
  localparam int NUM_REQ_D  = 4;
  localparam int LEN_W_D    = 4;
  localparam int CS_SETUP_D = 2;
  localparam int CS_HOLD_D  = 2;
  localparam int CS_GAP_D   = 1;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// spi_xfer_arbiter_if: requester and engine signals of the transfer arbiter
interface spi_xfer_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ*8-1:0]     tx_data;
  logic [NUM_REQ-1:0]       tx_pop;
  logic [7:0]               rx_data;
  logic [NUM_REQ-1:0]       rx_valid;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       cs_n;
  logic                     busy;
  logic                     eng_start;
  logic [7:0]               eng_tx_data;
  logic                     eng_done;
  logic [7:0]               eng_rx_data;
  modport slave (
    input  req_valid, req_len, tx_data, eng_done, eng_rx_data,
    output tx_pop, rx_data, rx_valid, done, cs_n, busy, eng_start, eng_tx_data
  );
  modport master (
    output req_valid, req_len, tx_data, eng_done, eng_rx_data,
    input  tx_pop, rx_data, rx_valid, done, cs_n, busy, eng_start, eng_tx_data
  );
endinterface

// File: rtl/spi_xfer_arbiter_rr.sv
// spi_rr_arbiter: first request at or above ptr, wrapping, as one-hot and index
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);
  logic [ID_W-1:0] idx;
  // scan offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    idx    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        gnt_id = idx;
        any    = 1'b1;
      end
    end
  end
  assign gnt = any ? (NUM_REQ'(1) << gnt_id) : '0;
endmodule

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one SPI byte engine with chip-select framing
module spi_xfer_arbiter
  import spi_xfer_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_D,
  parameter int LEN_W    = LEN_W_D,
  parameter int CS_SETUP = CS_SETUP_D,
  parameter int CS_HOLD  = CS_HOLD_D,
  parameter int CS_GAP   = CS_GAP_D
) (
  input logic               clk,
  input logic               rst,
  spi_xfer_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int PH_W = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);
  spi_arb_state_e     state;
  logic [ID_W-1:0]    ptr, gnt_id, rr_id;
  logic [NUM_REQ-1:0] rr_gnt, gnt_oh;
  logic               rr_any, go;
  logic [LEN_W-1:0]   cnt;
  logic [PH_W-1:0]    ph;
  logic [NUM_REQ-1:0] tx_pop, rx_valid, done, cs_n;
  logic [7:0]         rx_data, eng_tx_data;
  logic               busy, eng_start;
  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .gnt   (rr_gnt),
    .gnt_id(rr_id),
    .any   (rr_any)
  );
  assign gnt_oh = NUM_REQ'(1) << gnt_id;
  // in WAIT a nonzero ph marks the spacer cycle between eng_done and the next byte
  assign go = (state == SETUP && ph == '0) || (state == WAIT && ph != '0);
  // burst sequencer: grant, CS setup, byte loop, CS hold, gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt_id      <= '0;
      cnt         <= '0;
      ph          <= '0;
      tx_pop      <= '0;
      rx_valid    <= '0;
      done        <= '0;
      cs_n        <= '1;
      rx_data     <= '0;
      eng_tx_data <= '0;
      busy        <= 1'b0;
      eng_start   <= 1'b0;
    end else begin
      eng_start <= go;
      tx_pop    <= go ? gnt_oh : '0;
      rx_valid  <= '0;
      done      <= '0;
      if (go) eng_tx_data <= bus.tx_data[gnt_id*8 +: 8];
      case (state)
        IDLE: if (rr_any) begin
          gnt_id <= rr_id;
          cnt    <= bus.req_len[rr_id*LEN_W +: LEN_W];
          ptr    <= (rr_id == ID_W'(NUM_REQ - 1)) ? '0 : rr_id + 1'b1;
          cs_n   <= ~rr_gnt;
          busy   <= 1'b1;
          ph     <= PH_W'(CS_SETUP - 1);
          state  <= SETUP;
        end
        SETUP: begin
          ph    <= go ? ph : ph - 1'b1;
          state <= go ? XFER : SETUP;
        end
        XFER: begin
          ph    <= '0;
          state <= WAIT;
        end
        WAIT: if (go) begin
          ph    <= '0;
          state <= XFER;
        end else if (bus.eng_done) begin
          rx_data  <= bus.eng_rx_data;
          rx_valid <= gnt_oh;
          cnt      <= (cnt != '0) ? cnt - 1'b1 : cnt;
          ph       <= (cnt != '0) ? PH_W'(1) : PH_W'(CS_HOLD - 1);
          done     <= (cnt == '0 && CS_HOLD == 1) ? gnt_oh : '0;
          state    <= (cnt != '0) ? WAIT : HOLD;
        end
        HOLD: if (ph == '0) begin
          cs_n  <= '1;
          ph    <= PH_W'(CS_GAP - 1);
          state <= GAP;
        end else begin
          done <= (ph == PH_W'(1)) ? gnt_oh : '0;
          ph   <= ph - 1'b1;
        end
        GAP: if (ph == '0) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else ph <= ph - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.tx_pop      = tx_pop;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.done        = done;
  assign bus.cs_n        = cs_n;
  assign bus.busy        = busy;
  assign bus.eng_start   = eng_start;
  assign bus.eng_tx_data = eng_tx_data;
endmodule
